// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types for the posted write buffer.
//   wb_state_e : bus-side FSM states (IDLE, WR_BUS, RD_BUS)
//   wb_entry_t : one buffered write {addr, data} at the default 32-bit width.
//                The FIFO declares its own copy of this layout sized by its
//                WIDTH parameter, so non-default widths are not tied to this one.
package mem_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_BUS = 2'd1,
        RD_BUS = 2'd2
    } wb_state_e;

    localparam int WB_WIDTH = 32;

    typedef struct packed {
        logic [WB_WIDTH-1:0] addr;
        logic [WB_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer_fifo.sv
// wb_fifo: circular FIFO of posted writes {addr, data}.
// Optional feature macro: WB_READ_BYPASS_EN (adds match_addr / addr_hit).
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   push, push_addr/data      enqueue (ignored while full)
//   pop                       dequeue head (ignored while empty)
//   head_addr, head_data      oldest entry
//   full, empty, count        occupancy
//   match_addr, addr_hit      (bypass builds) match against every valid entry
module wb_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_addr,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
`ifdef WB_READ_BYPASS_EN
    ,
    input  logic [WIDTH-1:0] match_addr,
    output logic             addr_hit
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_addr = mem_q[head_q].addr;
    assign head_data = mem_q[head_q].data;

    // full/empty are start-of-cycle values, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle (no fall-through).
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[tail_q] = '{addr: push_addr, data: push_data};
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef WB_READ_BYPASS_EN
    // Slot i is valid when its distance from head is below count.
    logic [PTR_W-1:0] offs;
    always_comb begin
        addr_hit = 1'b0;
        offs     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - head_q;
            if (({1'b0, offs} < count_q) && (mem_q[i].addr == match_addr)) begin
                addr_hit = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted write buffer between the cache controller's memory
// handshake and the main-memory bus. Writes are acknowledged one cycle after
// acceptance and drained in order; reads are ordered behind buffered writes.
// Optional feature macro: WB_READ_BYPASS_EN -- a read whose address matches no
// buffered entry may go to the bus ahead of the buffered writes.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   address, wdata               request from cache controller
//   mem_read, mem_write          level requests, held until mem_ready
//   mem_ready, mem_rdata         registered completion pulse / read data
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_ack, bus_rdata memory bus
//   full, empty, count           buffer occupancy
//
// state  | meaning
// IDLE   | no bus transfer; choose read or head write
// WR_BUS | head entry on the bus, popped on bus_ack
// RD_BUS | read of `address` on the bus, data captured on bus_ack
module mem_write_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         address,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     mem_read,
    input  logic                     mem_write,
    output logic                     mem_ready,
    output logic [WIDTH-1:0]         mem_rdata,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [WIDTH-1:0]         bus_addr,
    output logic [WIDTH-1:0]         bus_wdata,
    input  logic                     bus_ack,
    input  logic [WIDTH-1:0]         bus_rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    import mem_wb_pkg::*;

    wb_state_e          state_q, state_d;
    logic               mem_ready_q, mem_ready_d;
    logic [WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
    logic               push, pop;
    logic               rd_pending, rd_go;
    logic [WIDTH-1:0]   head_addr, head_data;

    // mem_ready_q blocks a second push while the requester still holds
    // mem_write during the acknowledge cycle.
    assign push = mem_write && !full && !mem_ready_q;

    // A read seen together with a write is ignored until the write is acked.
    assign rd_pending = mem_read && !mem_write && !mem_ready_q;

`ifdef WB_READ_BYPASS_EN
    logic addr_hit;
    assign rd_go = rd_pending && (empty || !addr_hit);
`else
    assign rd_go = rd_pending && empty;
`endif

    wb_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (address),
        .push_data  (wdata),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef WB_READ_BYPASS_EN
        ,
        .match_addr (address),
        .addr_hit   (addr_hit)
`endif
    );

    // Bus outputs decode from the state register only; head and address are
    // stable while a transfer is outstanding, so the bus fields stay stable.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_ready_d = push;
        mem_rdata_d = mem_rdata_q;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (rd_go) begin
                    state_d = RD_BUS;
                end else if (!empty) begin
                    state_d = WR_BUS;
                end
            end
            WR_BUS: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = head_addr;
                bus_wdata = head_data;
                if (bus_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_BUS: begin
                bus_req  = 1'b1;
                bus_addr = address;
                if (bus_ack) begin
                    mem_rdata_d = bus_rdata;
                    mem_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

endmodule
